posit_decode_8bit: RTL and testbench

Registered decoder that converts an 8-bit posit (es = 0) into a 12-bit unpacked "uposit" word: special-value flags, sign, biased exponent and left-aligned fraction. It sits at the front of the posit arithmetic datapath and feeds the unpacked operands to the downstream add/multiply units. It uses a single valid-qualified stream and has no backpressure.

---
 rtl/posit_decode_8bit_if.sv | 11 +
 rtl/posit_decode_8bit.sv | 97 +++++++++
 tb/tb_posit_decode_8bit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/posit_decode_8bit_if.sv
// Valid-only stream carrying a raw 8-bit posit in and the unpacked 12-bit uposit out.
// master drives the posit side and observes the result; slave is the decoder.
interface posit_decode_8bit_if;
    logic        in_valid;
    logic [7:0]  posit;
    logic        out_valid;
    logic [11:0] uposit;

    modport master (output in_valid, posit, input  out_valid, uposit);
    modport slave  (input  in_valid, posit, output out_valid, uposit);
endinterface

// File: rtl/posit_decode_8bit.sv
// posit_decode_8bit: 8-bit es=0 posit -> uposit {nar,zero,sign,exp+6,frac[4:0]}; latency 1, or 2 with POSIT_DECODE_PIPE_EN.
// No backpressure: every in_valid beat yields one out_valid beat; idle cycles hold uposit.
module posit_decode_8bit (
    input  logic               clk,
    input  logic               rst_n,
    posit_decode_8bit_if.slave io
);
    typedef struct packed {
        logic       nar;
        logic       zero;
        logic       sign;
        logic       r;
        logic [3:0] run;
        logic [4:0] tail;
    } dec_t;

    dec_t        dec_d;
    dec_t        dec_b;
    logic        stage_vld;
    logic [6:0]  mag;
    logic        stop;
    logic [3:0]  exp_b;
    logic [4:0]  frac_b;
    logic [11:0] uposit_d;
    logic        out_valid_q;
    logic [11:0] uposit_q;

    // Only the low 7 bits of the two's-complement magnitude matter once 0x80 is excluded.
    always_comb begin
        mag        = io.posit[7] ? (~io.posit[6:0] + 7'd1) : io.posit[6:0];
        dec_d      = '0;
        dec_d.nar  = (io.posit == 8'h80);
        dec_d.zero = (io.posit == 8'h00);
        dec_d.sign = io.posit[7];
        dec_d.r    = mag[6];
        dec_d.tail = mag[4:0];
        dec_d.run  = 4'd1;
        stop       = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (!stop && (mag[i] == dec_d.r)) begin
                dec_d.run = dec_d.run + 4'd1;
            end else begin
                stop = 1'b1;
            end
        end
    end

`ifdef POSIT_DECODE_PIPE_EN
    logic s1_vld_q;
    dec_t s1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
        end else begin
            s1_vld_q <= io.in_valid;
            if (io.in_valid) begin
                s1_q <= dec_d;
            end
        end
    end

    assign dec_b     = s1_q;
    assign stage_vld = s1_vld_q;
`else
    assign dec_b     = dec_d;
    assign stage_vld = io.in_valid;
`endif

    // Shifting the tail left by run-1 pushes regime remnants and the terminator out the top.
    always_comb begin
        exp_b    = dec_b.r ? (dec_b.run + 4'd5) : (4'd6 - dec_b.run);
        frac_b   = dec_b.tail << (dec_b.run - 4'd1);
        uposit_d = {2'b00, dec_b.sign, exp_b, frac_b};
        if (dec_b.nar) begin
            uposit_d = 12'h800;
        end else if (dec_b.zero) begin
            uposit_d = 12'h400;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            uposit_q    <= 12'h000;
        end else begin
            out_valid_q <= stage_vld;
            if (stage_vld) begin
                uposit_q <= uposit_d;
            end
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.uposit    = uposit_q;
endmodule

// File: tb/tb_posit_decode_8bit.sv
// Bench for posit_decode_8bit: reference table built by encoding every (k, fraction) pair,
// delay-line model of the valid stream, directed vectors plus shuffled exhaustive and random traffic.
module tb_posit_decode_8bit;
`ifdef POSIT_DECODE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;
    posit_decode_8bit_if bus ();

    posit_decode_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_bad;
    logic [11:0] ref_tab [256];
    logic [12:0] dly_q [$];
    logic        exp_vld;
    logic [11:0] exp_up;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Encoder-side model: enumerate regime value k and every fraction pattern, write the posit bits.
    task automatic build_ref();
        int n, nf, acc;
        for (int i = 0; i < 256; i++) ref_tab[i] = 12'hxxx;
        for (int k = -6; k <= 6; k++) begin
            n  = (k >= 0) ? k + 1 : -k;
            nf = (n < 7) ? 6 - n : 0;
            for (int f = 0; f < (1 << nf); f++) begin
                acc = 0;
                for (int b = 0; b < n; b++) acc = acc * 2 + ((k >= 0) ? 1 : 0);
                if (n < 7) acc = acc * 2 + ((k >= 0) ? 0 : 1);
                acc = acc * (1 << nf) + f;
                ref_tab[acc] = 12'((k + 6) * 32 + f * (1 << (5 - nf)));
            end
        end
        for (int p = 1; p < 128; p++) ref_tab[256 - p] = ref_tab[p] | 12'h200;
        ref_tab[0]   = 12'h400;
        ref_tab[128] = 12'h800;
    endtask

    task automatic model_reset();
        dly_q.delete();
        for (int i = 0; i < LAT - 1; i++) dly_q.push_back(13'h0);
        exp_vld = 1'b0;
        exp_up  = 12'h000;
    endtask

    // One clock: drive, advance the model at the edge, sample 1 time unit later.
    task automatic cyc(input logic v, input logic [7:0] p, input logic use_xp, input logic [11:0] xp);
        logic [12:0] e;
        bus.in_valid = v;
        bus.posit    = p;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            dly_q.push_back(v ? {1'b1, (use_xp ? xp : ref_tab[p])} : 13'h0);
            e       = dly_q.pop_front();
            exp_vld = e[12];
            if (e[12]) exp_up = e[11:0];
        end
        #1;
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_vld});
        check(use_xp ? "uposit_directed" : "uposit", {20'd0, bus.uposit}, {20'd0, exp_up});
        if (bus.out_valid && !bus.uposit[11] && !bus.uposit[10])
            check("exp_le_12", {31'd0, (bus.uposit[8:5] <= 4'd12)}, 32'd1);
    endtask

    logic [7:0]  dp [13] = '{8'h76, 8'h16, 8'h57, 8'h40, 8'h8A, 8'hEA, 8'hA9, 8'hFF,
                             8'h7F, 8'h01, 8'h81, 8'h00, 8'h80};
    logic [11:0] dx [13] = '{12'h118, 12'h08C, 12'h0D7, 12'h0C0, 12'h318, 12'h28C, 12'h2D7, 12'h200,
                             12'h180, 12'h000, 12'h380, 12'h400, 12'h800};
    logic [7:0]  perm [256];

    initial begin
        n_vec = 0;
        n_bad = 0;
        build_ref();
        model_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.posit    = 8'h76;

        // Reset held with a valid input present must still yield nothing.
        cyc(1'b1, 8'h76, 1'b0, 12'h0);
        cyc(1'b1, 8'h76, 1'b0, 12'h0);
        rst_n = 1'b1;

        // Directed vectors back-to-back; literal expectations ride the delay line.
        for (int i = 0; i < 13; i++) cyc(1'b1, dp[i], 1'b1, dx[i]);
        for (int i = 0; i < 3 + LAT; i++) cyc(1'b0, 8'h00, 1'b0, 12'h0);
        check("hold_after_nar", {20'd0, bus.uposit}, 32'h800);

        // All 256 encodings in a shuffled order, back-to-back.
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int j;
            logic [7:0] t;
            j       = $urandom_range(i, 0);
            t       = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 256; i++) cyc(1'b1, perm[i], 1'b0, 12'h0);

        // Random traffic with gaps, reset dropped in mid-stream.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) rst_n = 1'b0;
            if (i == 152) rst_n = 1'b1;
            cyc(($urandom_range(3, 0) != 0), 8'($urandom), 1'b0, 12'h0);
        end
        for (int i = 0; i < LAT + 1; i++) cyc(1'b0, 8'h00, 1'b0, 12'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
